// File: rtl/hysteresis_stream.sv
// Streaming Canny hysteresis: 2-bit strengths in, one edge byte out per pixel.
// Two line buffers build the 3x3 window; valid/ready on both sides.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   str_in          pixel strength (00 none, 01 weak, 10 strong, 11 as 00)
//   str_valid/ready input handshake
//   edge_out        EDGE_VAL or 8'h00
//   edge_out_valid/ready output handshake
//   frame_done      pulses with acceptance of the frame's last output pixel
module hysteresis_stream #(
  parameter int          IMG_WIDTH  = 640,
  parameter int          IMG_HEIGHT = 480,
  parameter int          CONNECT    = 8,
  parameter logic [7:0]  EDGE_VAL   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] str_in,
  input  logic       str_valid,
  output logic       str_ready,
  output logic [7:0] edge_out,
  output logic       edge_out_valid,
  input  logic       edge_out_ready,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int FW = $clog2(IMG_WIDTH + 2);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0] FILL_N   = FW'(IMG_WIDTH + 1);
  localparam bit            DIAG     = (CONNECT == 8);

  localparam logic [1:0] ST = 2'b10;
  localparam logic [1:0] WK = 2'b01;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t state_q, state_d;

  logic          armed;
  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic [CW-1:0] lb_col;
  logic [CW-1:0] c_col;
  logic [RW-1:0] c_row;
  logic [FW-1:0] fill_cnt;
  logic          last_q;

  // Window: column a is the older one, b the newer one.
  // The centre always sits in b_m when a step happens.
  logic [1:0] a_t, a_m, a_b;
  logic [1:0] b_t, b_m, b_b;

  logic [1:0] lb1 [IMG_WIDTH];
  logic [1:0] lb2 [IMG_WIDTH];
  logic [1:0] lb1_rd, lb2_rd;

  logic       slot_free;
  logic       acc;
  logic       step;
  logic       last_in;
  logic       have_c;
  logic       last_c;
  logic [1:0] px;
  logic       n_ok, s_ok, w_ok, e_ok;
  logic       cross_nb, diag_nb;
  logic [7:0] edge_d;

  assign lb1_rd = lb1[lb_col];
  assign lb2_rd = lb2[lb_col];

  always_comb begin
    state_d   = state_q;
    slot_free = !edge_out_valid || edge_out_ready;
    str_ready = armed && (state_q == RUN) && slot_free;
    acc       = str_valid && str_ready;
    step      = acc || ((state_q == FLUSH) && slot_free);
    last_in   = (in_col == COL_LAST) && (in_row == ROW_LAST);
    have_c    = (fill_cnt == FILL_N);
    last_c    = have_c && (c_col == COL_LAST) && (c_row == ROW_LAST);
    // Flush feeds virtual 00 pixels.
    px        = acc ? str_in : 2'b00;
    unique case (state_q)
      RUN:   if (acc && last_in) state_d = FLUSH;
      FLUSH: if (step && last_c) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    n_ok     = (c_row != '0);
    s_ok     = (c_row != ROW_LAST);
    w_ok     = (c_col != '0);
    e_ok     = (c_col != COL_LAST);
    cross_nb = (n_ok && b_t == ST) ||
               (s_ok && b_b == ST) ||
               (w_ok && a_m == ST) ||
               (e_ok && lb1_rd == ST);
    diag_nb  = (n_ok && w_ok && a_t == ST) ||
               (n_ok && e_ok && lb2_rd == ST) ||
               (s_ok && w_ok && a_b == ST) ||
               (s_ok && e_ok && px == ST);
    edge_d   = 8'h00;
    unique case (1'b1)
      (b_m == ST):
        edge_d = EDGE_VAL;
      (b_m == WK) && (cross_nb || (DIAG && diag_nb)):
        edge_d = EDGE_VAL;
      default:
        edge_d = 8'h00;
    endcase
  end

  assign frame_done = edge_out_valid && edge_out_ready && last_q;

  // Line-buffer RAM: not reset, stale contents are masked by c_row/c_col.
  always_ff @(posedge clk) begin
    if (step) begin
      lb1[lb_col] <= px;
      lb2[lb_col] <= lb1_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      armed          <= 1'b0;
      in_col         <= '0;
      in_row         <= '0;
      lb_col         <= '0;
      c_col          <= '0;
      c_row          <= '0;
      fill_cnt       <= '0;
      last_q         <= 1'b0;
      a_t            <= '0;
      a_m            <= '0;
      a_b            <= '0;
      b_t            <= '0;
      b_m            <= '0;
      b_b            <= '0;
      edge_out       <= '0;
      edge_out_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      armed   <= 1'b1;
      if (step) begin
        lb_col <= (lb_col == COL_LAST) ? '0 : lb_col + CW'(1);
        a_t    <= b_t;
        a_m    <= b_m;
        a_b    <= b_b;
        b_t    <= lb2_rd;
        b_m    <= lb1_rd;
        b_b    <= px;
        if (acc) begin
          if (in_col == COL_LAST) begin
            in_col <= '0;
            in_row <= (in_row == ROW_LAST) ? '0 : in_row + RW'(1);
          end else begin
            in_col <= in_col + CW'(1);
          end
        end
        // Frame ends with the last centre: rearm the fill phase.
        if (last_c)
          fill_cnt <= '0;
        else if (!have_c)
          fill_cnt <= fill_cnt + FW'(1);
        if (have_c) begin
          if (c_col == COL_LAST) begin
            c_col <= '0;
            c_row <= (c_row == ROW_LAST) ? '0 : c_row + RW'(1);
          end else begin
            c_col <= c_col + CW'(1);
          end
          edge_out <= edge_d;
          last_q   <= last_c;
        end
        edge_out_valid <= have_c;
      end else if (edge_out_ready) begin
        edge_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hysteresis_stream.sv
// Bench for hysteresis_stream: random/directed frames vs. a pixel-level model.
// Two instances (8- and 4-connectivity) share the same stimulus.
module tb_hysteresis_stream;

  localparam int         W   = 8;
  localparam int         H   = 4;
  localparam int         NPX = W * H;
  localparam logic [7:0] EV  = 8'hFF;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] str_in;
  logic       str_valid;
  logic       edge_out_ready;

  logic       rdy8, v8, fd8;
  logic [7:0] e8;
  logic       rdy4, v4, fd4;
  logic [7:0] e4;

  always #5 clk = ~clk;

  hysteresis_stream #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .CONNECT(8), .EDGE_VAL(EV)
  ) u_dut8 (
    .clk(clk), .rst(rst),
    .str_in(str_in), .str_valid(str_valid), .str_ready(rdy8),
    .edge_out(e8), .edge_out_valid(v8), .edge_out_ready(edge_out_ready),
    .frame_done(fd8)
  );

  hysteresis_stream #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .CONNECT(4), .EDGE_VAL(EV)
  ) u_dut4 (
    .clk(clk), .rst(rst),
    .str_in(str_in), .str_valid(str_valid), .str_ready(rdy4),
    .edge_out(e4), .edge_out_valid(v4), .edge_out_ready(edge_out_ready),
    .frame_done(fd4)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [1:0] pix[$];
  int total, px_idx;
  int o8, o4, x8, x4, fdc8, fdc4, ed8, ed4;
  int vp, rp;
  bit tog, tq, ignore, st8;
  logic [7:0] sv8;

  // Pixel k of the stream (frames concatenated in raster order).
  function automatic logic [7:0] ref_px(int k, int conn);
    int base, r, c, rr, cc;
    base = (k / NPX) * NPX;
    r = (k % NPX) / W;
    c = k % W;
    if (pix[k] == 2'b10) return EV;
    if (pix[k] != 2'b01) return 8'h00;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (dr == 0 && dc == 0) continue;
        if (conn == 4 && dr != 0 && dc != 0) continue;
        if (rr < 0 || rr >= H || cc < 0 || cc >= W) continue;
        if (pix[base + rr * W + cc] == 2'b10) return EV;
      end
    end
    return 8'h00;
  endfunction

  task automatic take(input int conn, input logic [7:0] e, input logic fd,
                      inout int o, inout int x, inout int ed);
    if (o < total) begin
      check($sformatf("px%0d_%0d", conn, o), {24'h0, e}, {24'h0, ref_px(o, conn)});
      check($sformatf("fd%0d_%0d", conn, o), {31'h0, fd},
            {31'h0, ((o % NPX) == NPX - 1)});
      if (e == EV) ed++;
      o++;
    end else begin
      x++;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    str_valid = (px_idx < total) && ($urandom_range(0, 99) < vp);
    str_in = str_valid ? pix[px_idx] : 2'($urandom);
    tq = ~tq;
    edge_out_ready = tog ? tq : ($urandom_range(0, 99) < rp);
    #1;
    if (st8) begin
      check("hold_valid", {31'h0, v8}, 32'd1);
      check("hold_data", {24'h0, e8}, {24'h0, sv8});
    end
    st8 = v8 && !edge_out_ready;
    sv8 = e8;
    if (st8) check("ready_stall", {31'h0, rdy8}, 32'd0);
    check("ready_sync", {31'h0, rdy4}, {31'h0, rdy8});
    if (str_valid && rdy8) px_idx++;
    if (!ignore) begin
      if (v8 && edge_out_ready) take(8, e8, fd8, o8, x8, ed8);
      if (v4 && edge_out_ready) take(4, e4, fd4, o4, x4, ed4);
      if (fd8) fdc8++;
      if (fd4) fdc4++;
    end
  endtask

  task automatic run(input int nf, input int v, input int r, input bit t);
    total = nf * NPX;
    px_idx = 0;
    o8 = 0; o4 = 0; x8 = 0; x4 = 0;
    fdc8 = 0; fdc4 = 0; ed8 = 0; ed4 = 0;
    vp = v; rp = r; tog = t;
    for (int i = 0; i < 3000 && (o8 < total || o4 < total); i++) cyc();
    check("count8", o8, total);
    check("count4", o4, total);
    vp = 0; rp = 100; tog = 0;
    for (int i = 0; i < 20; i++) cyc();
    check("extra8", x8, 0);
    check("extra4", x4, 0);
    check("frames8", fdc8, nf);
    check("frames4", fdc4, nf);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready8", {31'h0, rdy8}, 32'd0);
    check("rst_ready4", {31'h0, rdy4}, 32'd0);
    check("rst_valid", {31'h0, v8}, 32'd0);
    check("rst_data", {24'h0, e8}, 32'd0);
    check("rst_fdone", {31'h0, fd8}, 32'd0);
  endtask

  task automatic rand_img(input int nf);
    pix.delete();
    for (int k = 0; k < nf * NPX; k++) pix.push_back(2'($urandom));
  endtask

  initial begin
    rst = 1'b1;
    str_valid = 1'b0;
    str_in = 2'b00;
    edge_out_ready = 1'b0;
    tq = 1'b0; tog = 1'b0; ignore = 1'b0; st8 = 1'b0;
    total = 0; px_idx = 0; vp = 0; rp = 0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // All-zero frame: 32 zero outputs, one frame_done.
    pix.delete();
    for (int k = 0; k < NPX; k++) pix.push_back(2'b00);
    run(1, 100, 100, 1'b0);
    check("zero_edges", ed8, 0);

    // One strong at (1,3) in a sea of weak pixels.
    pix.delete();
    for (int k = 0; k < NPX; k++)
      pix.push_back((k == 1 * W + 3) ? 2'b10 : 2'b01);
    run(1, 100, 100, 1'b0);
    check("blob_edges8", ed8, 9);
    check("blob_edges4", ed4, 5);

    // Strong at end of row 0 must not leak into the start of row 1.
    pix.delete();
    for (int k = 0; k < NPX; k++) pix.push_back(2'b00);
    pix[7] = 2'b10;
    pix[8] = 2'b01;
    pix[15] = 2'b01;
    run(1, 80, 80, 1'b0);
    check("wrap_edges8", ed8, 2);
    check("wrap_edges4", ed4, 2);

    // Ready toggling every cycle with random input valid.
    rand_img(1);
    run(1, 60, 0, 1'b1);

    // Back-to-back random frames including reserved code 11.
    rand_img(3);
    run(3, 75, 70, 1'b0);

    // Reset after 13 accepted pixels, then a clean frame.
    rand_img(1);
    total = 13; px_idx = 0; vp = 100; rp = 100; tog = 0; ignore = 1'b1;
    for (int i = 0; i < 200 && px_idx < 13; i++) cyc();
    check("partial_px", px_idx, 13);
    @(negedge clk);
    rst = 1'b1;
    str_valid = 1'b0;
    st8 = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    ignore = 1'b0;
    rand_img(1);
    run(1, 80, 80, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
